// File: rtl/core_pkg.sv
// Shared definitions for the 9-bit core: instruction constants,
// branch encodings used by both the decoder and the fetch unit,
// and the fetch state enumeration.
package core_pkg;

    localparam int unsigned IW = 9;

    localparam logic [IW-1:0] NOP_INSTR  = 9'b001110000;
    localparam logic [IW-1:0] HALT_INSTR = 9'b000000000;

    localparam logic [1:0] BR_NONE   = 2'b00;
    localparam logic [1:0] BR_IFT    = 2'b01;
    localparam logic [1:0] BR_IFF    = 2'b10;
    localparam logic [1:0] BR_ALWAYS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch-target register file: LUT_N entries of PC_W bits, cleared by
// the asynchronous reset, one synchronous write port and one
// combinational read port.
module branch_lut #(
    parameter  int unsigned LUT_N = 16,
    parameter  int unsigned PC_W  = 10,
    localparam int unsigned AW    = $clog2(LUT_N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [PC_W-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [PC_W-1:0] rdata
);

    logic [PC_W-1:0] mem [LUT_N];

    // Clear every entry on reset, otherwise write one entry per strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LUT_N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch / program-counter unit. Drives the synchronous
// instruction ROM, presents fetched words to the decoder, redirects
// through the branch-target LUT and sequences start/halt.
module instr_fetch #(
    parameter  int unsigned PC_W  = 10,
    parameter  int unsigned IW    = core_pkg::IW,
    parameter  int unsigned LUT_N = 16,
    localparam int unsigned AW    = $clog2(LUT_N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic [1:0]      branch,
    input  logic [AW-1:0]   target_idx,
    input  logic            cond_flag,
    output logic [PC_W-1:0] rom_addr,
    input  logic [IW-1:0]   rom_data,
    input  logic            lut_we,
    input  logic [AW-1:0]   lut_waddr,
    input  logic [PC_W-1:0] lut_wdata,
    output logic [IW-1:0]   instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] exec_pc,
    output logic            done
);

    import core_pkg::*;

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] lut_target;
    logic            lut_wen;
    logic            taken;
    logic            is_halt;

    // The LUT is only loadable while the core is not running.
    assign lut_wen = lut_we && (state != ST_RUN);

    branch_lut #(
        .LUT_N (LUT_N),
        .PC_W  (PC_W)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lut_wen),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (target_idx),
        .rdata (lut_target)
    );

    // While stalled the ROM is re-addressed with the word already on
    // instr, so it keeps presenting the same data.
    assign rom_addr = (state == ST_RUN && stall) ? exec_pc : pc;
    assign instr    = instr_valid ? rom_data : IW'(NOP_INSTR);

    // Branch and halt decisions only apply to a real, non-stalled word.
    always_comb begin
        taken   = 1'b0;
        is_halt = 1'b0;
        if (instr_valid && !stall) begin
            is_halt = (rom_data == IW'(HALT_INSTR));
            case (branch)
                BR_NONE:   taken = 1'b0;
                BR_IFT:    taken = cond_flag;
                BR_IFF:    taken = !cond_flag;
                BR_ALWAYS: taken = 1'b1;
                default:   taken = 1'b0;
            endcase
        end
    end

    // Sequencer, PC datapath and valid/flush registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            exec_pc     <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state       <= ST_RUN;
                        pc          <= '0;
                        done        <= 1'b0;
                        instr_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (is_halt) begin
                            state       <= ST_HALT;
                            done        <= 1'b1;
                            instr_valid <= 1'b0;
                        end else if (taken) begin
                            // The word fetched at pc is in flight; drop it.
                            exec_pc     <= pc;
                            pc          <= lut_target;
                            instr_valid <= 1'b0;
                        end else begin
                            exec_pc     <= pc;
                            pc          <= pc + PC_W'(1);
                            instr_valid <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
